dmem_arbiter: RTL and testbench

- Shares the single-port, word-addressed data memory between two requesters:
  - port 0: core load/store unit;
  - port 1: loader/debug master.
- Round-robin arbitration with a valid/ready request handshake.
- Drives the memory's read/write strobes, address and write data; memory read data is combinational.
- Returns a registered response to the winning requester one cycle after acceptance.
- Sits between the core/loader and the data memory; it is the only driver of the memory strobes.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_rr_pick2.sv | 17 +
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: port ids, default widths and the response record shared by the data-memory arbiter
package dmem_arb_pkg;
  localparam int PORT_LSU = 0;
  localparam int PORT_DBG = 1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MEM_DEPTH_DEF = 256;
  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } rsp_t;
endpackage

// File: rtl/dmem_rr_pick2.sv
// dmem_rr_pick2: two-input round-robin picker with one-hot grant; last grant resets to port 1
// ports: clk, rst (sync, active-high), req[1:0] requests in, gnt[1:0] one-hot grant out
module dmem_rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    gnt = (&req) ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = (|req) ? gnt[PORT_DBG] : last_q;
  end
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port word-addressed data memory between the LSU (port 0) and loader/debug (port 1)
// ports: clk, rst (sync, active-high); reqN_valid/we/addr/wdata in, reqN_ready out;
//   rspN_valid/rdata/err registered response one cycle after acceptance;
//   mem_read/mem_write/mem_addr/mem_wdata to memory, mem_rdata combinational from memory;
//   with DMEM_ARB_STATS_EN: stats_clr in, stat_grant0/stat_grant1/stat_conflict saturating counters out
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
  output logic [31:0]       stat_conflict
`endif
);
  logic [1:0] req, gnt;
  logic any, sel, we, oor;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rd;
  rsp_t rsp_q [2];
  rsp_t rsp_d [2];
  // masking requests during reset keeps strobes and ready low while rst is held
  assign req = {req1_valid, req0_valid} & {2{~rst}};
  dmem_rr_pick2 u_pick (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt)
  );
  always_comb begin
    any = |gnt;
    sel = gnt[PORT_DBG];
    we = sel ? req1_we : req0_we;
    addr = sel ? req1_addr : req0_addr;
    wdata = sel ? req1_wdata : req0_wdata;
    oor = addr >= ADDR_W'(MEM_DEPTH);
    mem_read = any & ~oor & ~we;
    mem_write = any & ~oor & we;
    mem_addr = any ? addr : '0;
    mem_wdata = any ? wdata : '0;
    rd = (oor | we) ? '0 : mem_rdata;
    for (int i = 0; i < 2; i++)
      rsp_d[i] = gnt[i] ? {1'b1, rd, oor} : {1'b0, rsp_q[i].rdata, rsp_q[i].err};
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++) rsp_q[i] <= rst ? '0 : rsp_d[i];
  assign req0_ready = gnt[PORT_LSU];
  assign req1_ready = gnt[PORT_DBG];
  // a response already registered is dropped as soon as reset is seen
  assign rsp0_valid = rsp_q[PORT_LSU].valid & ~rst;
  assign rsp0_rdata = rsp_q[PORT_LSU].rdata;
  assign rsp0_err = rsp_q[PORT_LSU].err;
  assign rsp1_valid = rsp_q[PORT_DBG].valid & ~rst;
  assign rsp1_rdata = rsp_q[PORT_DBG].rdata;
  assign rsp1_err = rsp_q[PORT_DBG].err;
`ifdef DMEM_ARB_STATS_EN
  logic clr;
  logic [31:0] stat_grant0_q, stat_grant0_d, stat_grant1_q, stat_grant1_d, stat_conflict_q, stat_conflict_d;
  always_comb begin
    clr = rst | stats_clr;
    stat_grant0_d = clr ? '0 : stat_grant0_q + 32'(gnt[PORT_LSU] & ~&stat_grant0_q);
    stat_grant1_d = clr ? '0 : stat_grant1_q + 32'(gnt[PORT_DBG] & ~&stat_grant1_q);
    stat_conflict_d = clr ? '0 : stat_conflict_q + 32'(&req & ~&stat_conflict_q);
  end
  always_ff @(posedge clk) begin
    stat_grant0_q <= stat_grant0_d;
    stat_grant1_q <= stat_grant1_d;
    stat_conflict_q <= stat_conflict_d;
  end
  assign stat_grant0 = stat_grant0_q;
  assign stat_grant1 = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter against a rule-level reference model
module tb_dmem_arbiter;
  logic clk, rst, preload;
  logic req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata, req1_addr, req1_wdata, rsp1_rdata;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic ev [2];
  logic ee [2];
  logic [31:0] ed [2];
  int last_g, checks, fails, g;
  logic pv [2];
  logic pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
`ifdef DMEM_ARB_STATS_EN
  logic stats_clr;
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_conflict(stat_conflict)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory environment: out-of-range reads return a marker the arbiter must never forward
  assign mem_rdata = (mem_addr < 256) ? mem[mem_addr[7:0]] : 32'hA5A5_A5A5;
  always @(posedge clk)
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    else if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // one cycle: drive at negedge, check combinational and registered outputs, advance the model
  task automatic step(input logic r, input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      output int gout);
    int gg;
    logic w;
    logic [31:0] a, d;
    rst = r;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    if (r || !(v0 || v1)) gg = -1;
    else if (v0 && v1) gg = (last_g == 0) ? 1 : 0;
    else gg = v0 ? 0 : 1;
    w = (gg == 1) ? w1 : w0;
    a = (gg == 1) ? a1 : a0;
    d = (gg == 1) ? d1 : d0;
    chk1("req0_ready", req0_ready, gg == 0);
    chk1("req1_ready", req1_ready, gg == 1);
    chk1("mem_read", mem_read, gg >= 0 && a < 256 && !w);
    chk1("mem_write", mem_write, gg >= 0 && a < 256 && w);
    chk("mem_addr", mem_addr, (gg >= 0) ? a : 32'h0);
    chk("mem_wdata", mem_wdata, (gg >= 0) ? d : 32'h0);
    chk1("rsp0_valid", rsp0_valid, !r && ev[0]);
    chk1("rsp1_valid", rsp1_valid, !r && ev[1]);
    chk("rsp0_rdata", rsp0_rdata, ed[0]);
    chk("rsp1_rdata", rsp1_rdata, ed[1]);
    chk1("rsp0_err", rsp0_err, ee[0]);
    chk1("rsp1_err", rsp1_err, ee[1]);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        ev[i] = 0; ed[i] = 0; ee[i] = 0;
      end
      last_g = 1;
    end else begin
      ev[0] = (gg == 0);
      ev[1] = (gg == 1);
      if (gg >= 0) begin
        ed[gg] = (a < 256 && !w) ? ref_mem[a[7:0]] : 32'h0;
        ee[gg] = (a >= 256);
        if (a < 256 && w) ref_mem[a[7:0]] = d;
        last_g = gg;
      end
    end
    @(negedge clk);
    gout = gg;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    last_g = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    for (int i = 0; i < 2; i++) begin
      ev[i] = 0; ed[i] = 0; ee[i] = 0; pv[i] = 0; pw[i] = 0; pa[i] = 0; pd[i] = 0;
    end
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 0;
`endif
    preload = 1;
    rst = 1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    @(negedge clk);
    preload = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g);
    step(1, 1, 1, 7, 32'h1111_2222, 1, 0, 9, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 0, 1, 0, 2, 0, g);
    step(0, 1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, g);
    step(0, 1, 0, 5, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 256, 0, g);
    step(0, 0, 0, 0, 0, 1, 1, 300, 32'hCAFE_F00D, g);
    step(0, 1, 0, 255, 0, 0, 0, 0, 0, g);
    step(0, 1, 0, 3, 0, 0, 0, 0, 0, g);
    step(1, 1, 0, 4, 0, 1, 0, 6, 0, g);
    step(0, 1, 0, 4, 0, 1, 0, 6, 0, g);
    step(0, 1, 0, 4, 0, 1, 0, 6, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i]) begin
          pv[i] = ($urandom_range(0, 99) < 65);
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 263)) : 32'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
      step(($urandom_range(0, 99) == 0), pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], g);
      if (g >= 0) pv[g] = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
`ifdef DMEM_ARB_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 0, 1, 0, 2, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 3, 0, g);
    chk("stat_grant0", stat_grant0, 32'd2);
    chk("stat_grant1", stat_grant1, 32'd2);
    chk("stat_conflict", stat_conflict, 32'd3);
    stats_clr = 1;
    step(0, 1, 0, 1, 0, 1, 0, 2, 0, g);
    stats_clr = 0;
    chk("stat_grant0_clr", stat_grant0, 32'd0);
    chk("stat_grant1_clr", stat_grant1, 32'd0);
    chk("stat_conflict_clr", stat_conflict, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
